cim_banked_mem_ctrl: RTL and testbench

//  Parametrised controller for the banked CIM parameter and intermediate-result SRAMs.
//  - Decodes a flat word address into a bank index and an in-bank offset.
//  - Performs single-word or double-word (2*DATA_W) reads and writes; double accesses may cross a bank boundary.
//  - Optional sign extension of single-word reads.
//  - valid/ready handshake on both the request and response sides.
//  - One instance per memory: params = 2x15872x9, int-res = 4x14336x9.

---
 rtl/cim_banked_mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cim_banked_mem_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_banked_mem_ctrl.sv
// Banked SRAM controller for the CIM parameter / intermediate-result memories.
// Splits a flat word address into bank index and in-bank offset, then runs
// single- or double-word accesses (doubles may straddle two banks) behind
// valid/ready handshakes on the request and response sides.
module cim_banked_mem_ctrl #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 14336,
  parameter int DATA_W     = 9,
  parameter int ADDR_W     = $clog2(NUM_BANKS*BANK_DEPTH),
  parameter int OFF_W      = $clog2(BANK_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic                          req_double,
  input  logic                          req_signed,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [2*DATA_W-1:0]           req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2*DATA_W-1:0]           rsp_data,
  output logic                          rsp_err,
  output logic [NUM_BANKS-1:0]          bank_en,
  output logic                          bank_we,
  output logic [OFF_W-1:0]              bank_addr,
  output logic [DATA_W-1:0]             bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata
);

  localparam int BIDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  // One extra bit so the total size is representable even when it is 2**ADDR_W.
  localparam int EXT_W  = ADDR_W + 1;
  localparam logic [EXT_W-1:0] TOTAL_WORDS = EXT_W'(NUM_BANKS*BANK_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    CAP,
    RESP
  } state_t;

  state_t state;

  logic [EXT_W-1:0]    addr_ext;
  logic [EXT_W-1:0]    bank_base;
  logic [BIDX_W-1:0]   dec_bank;
  logic [OFF_W-1:0]    dec_off;
  logic                dec_last_off;
  logic [BIDX_W-1:0]   dec_hi_bank;
  logic [OFF_W-1:0]    dec_hi_off;
  logic                dec_err;

  logic                we_q;
  logic                dbl_q;
  logic                sgn_q;
  logic [DATA_W-1:0]   hi_wdata_q;
  logic [BIDX_W-1:0]   hi_bank_q;
  logic [OFF_W-1:0]    hi_off_q;
  logic [BIDX_W-1:0]   cur_bank;
  logic [BIDX_W-1:0]   prev_bank;
  logic [DATA_W-1:0]   lo_word_q;
  logic [DATA_W-1:0]   rd_word;

  function automatic logic [NUM_BANKS-1:0] onehot(input logic [BIDX_W-1:0] idx);
    onehot = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (idx == BIDX_W'(b)) onehot[b] = 1'b1;
    end
  endfunction

  // Address decode: the last bank base not above addr wins, so bank/offset
  // come from a comparator chain and one subtraction instead of a divider.
  always_comb begin
    addr_ext  = {1'b0, req_addr};
    dec_bank  = '0;
    bank_base = '0;
    for (int unsigned k = 1; k < NUM_BANKS; k++) begin
      if (addr_ext >= EXT_W'(k*BANK_DEPTH)) begin
        dec_bank  = BIDX_W'(k);
        bank_base = EXT_W'(k*BANK_DEPTH);
      end
    end
    dec_off      = OFF_W'(addr_ext - bank_base);
    dec_last_off = (dec_off == OFF_W'(BANK_DEPTH-1));
    dec_hi_bank  = dec_last_off ? dec_bank + BIDX_W'(1) : dec_bank;
    dec_hi_off   = dec_last_off ? '0 : dec_off + OFF_W'(1);
    dec_err      = (addr_ext >= TOTAL_WORDS) ||
                   (req_double && ((addr_ext + EXT_W'(1)) >= TOTAL_WORDS));
  end

  // Read-data mux steered by the bank driven one cycle earlier, matching the
  // one-cycle SRAM read latency.
  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (prev_bank == BIDX_W'(b)) rd_word = bank_rdata[b*DATA_W +: DATA_W];
    end
  end

  // Control FSM with registered handshake, response and bank-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      bank_en    <= '0;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      we_q       <= 1'b0;
      dbl_q      <= 1'b0;
      sgn_q      <= 1'b0;
      hi_wdata_q <= '0;
      hi_bank_q  <= '0;
      hi_off_q   <= '0;
      cur_bank   <= '0;
      prev_bank  <= '0;
      lo_word_q  <= '0;
    end else begin
      prev_bank <= cur_bank;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            we_q       <= req_we;
            dbl_q      <= req_double;
            sgn_q      <= req_signed;
            hi_wdata_q <= req_wdata[2*DATA_W-1:DATA_W];
            hi_bank_q  <= dec_hi_bank;
            hi_off_q   <= dec_hi_off;
            if (dec_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state      <= ACC0;
              cur_bank   <= dec_bank;
              bank_en    <= onehot(dec_bank);
              bank_we    <= req_we;
              bank_addr  <= dec_off;
              bank_wdata <= req_wdata[DATA_W-1:0];
            end
          end
        end
        ACC0: begin
          if (dbl_q) begin
            state      <= ACC1;
            cur_bank   <= hi_bank_q;
            bank_en    <= onehot(hi_bank_q);
            bank_we    <= we_q;
            bank_addr  <= hi_off_q;
            bank_wdata <= hi_wdata_q;
          end else begin
            bank_en    <= '0;
            bank_we    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            if (we_q) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= CAP;
            end
          end
        end
        ACC1: begin
          bank_en    <= '0;
          bank_we    <= 1'b0;
          bank_addr  <= '0;
          bank_wdata <= '0;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            lo_word_q <= rd_word;
            state     <= CAP;
          end
        end
        CAP: begin
          if (dbl_q) begin
            rsp_data <= {rd_word, lo_word_q};
          end else begin
            rsp_data <= {{DATA_W{sgn_q & rd_word[DATA_W-1]}}, rd_word};
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          bank_en   <= '0;
          bank_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_banked_mem_ctrl.sv
// Self-checking bench for cim_banked_mem_ctrl (4 x 14336 x 9 configuration).
// A flat-addressed SRAM model answers the bank ports; expected responses come
// from a separate flat reference memory updated only when the bench issues writes.
module tb_cim_banked_mem_ctrl;

  localparam int NB    = 4;
  localparam int D     = 14336;
  localparam int DW    = 9;
  localparam int AW    = 16;
  localparam int OW    = 14;
  localparam int TOTAL = NB*D;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic            req_double = 1'b0;
  logic            req_signed = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_err;
  logic [NB-1:0]   bank_en;
  logic            bank_we;
  logic [OW-1:0]   bank_addr;
  logic [DW-1:0]   bank_wdata;
  logic [NB*DW-1:0] bank_rdata;

  always #5 clk = ~clk;

  cim_banked_mem_ctrl #(
    .NUM_BANKS (NB),
    .BANK_DEPTH(D),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_double(req_double),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .bank_en   (bank_en),
    .bank_we   (bank_we),
    .bank_addr (bank_addr),
    .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  logic [DW-1:0] sram    [TOTAL];
  logic [DW-1:0] ref_mem [TOTAL];
  logic [DW-1:0] rd_r    [NB];
  int en_count = 0;
  int bad_en   = 0;
  int checks   = 0;
  int errors   = 0;

  // SRAM banks: one-cycle registered read, write on enable
  always @(posedge clk) begin
    if (bank_en != '0) begin
      en_count <= en_count + 1;
      if (!$onehot(bank_en) || bank_addr >= OW'(D)) begin
        bad_en <= bad_en + 1;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (bank_en[b]) begin
            if (bank_we) sram[b*D + int'(bank_addr)] = bank_wdata;
            else         rd_r[b] <= sram[b*D + int'(bank_addr)];
          end
        end
      end
    end
  end

  assign bank_rdata = {rd_r[3], rd_r[2], rd_r[1], rd_r[0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preset(input int a, input logic [DW-1:0] w);
    sram[a]    = w;
    ref_mem[a] = w;
  endtask

  task automatic launch(input logic we, input logic dbl, input logic sgn,
                        input int addr, input logic [2*DW-1:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_double = dbl;
    req_signed = sgn;
    req_addr   = AW'(addr);
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_double = 1'b0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp_seen", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic dbl, input logic sgn, input int addr,
                        input logic [2*DW-1:0] wdata, input int hold,
                        output logic [2*DW-1:0] data, output logic err,
                        output int lat, output int nacc);
    int c0;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    c0 = en_count;
    launch(we, dbl, sgn, addr, wdata);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    data = rsp_data;
    err  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, data);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    nacc = en_count - c0;
    check("post_req_ready", req_ready, 1);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_rsp_data", rsp_data, 0);
  endtask

  task automatic run_and_check(input logic we, input logic dbl, input logic sgn, input int addr,
                               input logic [2*DW-1:0] wdata, input int hold,
                               input logic exp_err, input int exp_lat,
                               input logic [2*DW-1:0] exp_data);
    logic [2*DW-1:0] d;
    logic e;
    int lat, nacc;
    do_req(we, dbl, sgn, addr, wdata, hold, d, e, lat, nacc);
    check("rsp_err", e, exp_err);
    check("latency", lat, exp_lat);
    check("rsp_data", d, exp_data);
    check("bank_accesses", nacc, exp_err ? 0 : (dbl ? 2 : 1));
    if (we && !exp_err) begin
      ref_mem[addr] = wdata[DW-1:0];
      if (dbl) ref_mem[addr+1] = wdata[2*DW-1:DW];
    end
  endtask

  // Reference behaviour derived from the flat-address view of memory.
  function automatic void model(input logic we, input logic dbl, input logic sgn, input int a,
                                output logic e, output int lat, output logic [2*DW-1:0] d);
    e = (a >= TOTAL) || (dbl && (a + 1 >= TOTAL));
    if (e)       lat = 1;
    else if (we) lat = dbl ? 3 : 2;
    else         lat = dbl ? 4 : 3;
    d = '0;
    if (!e && !we) begin
      if (dbl)      d = {ref_mem[a+1], ref_mem[a]};
      else if (sgn) d = {{DW{ref_mem[a][DW-1]}}, ref_mem[a]};
      else          d = {{DW{1'b0}}, ref_mem[a]};
    end
  endfunction

  typedef struct {
    logic            we;
    logic            dbl;
    logic            sgn;
    int              addr;
    logic [2*DW-1:0] wdata;
    int              hold;
    logic            exp_err;
    int              exp_lat;
    logic [2*DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e;
    int lat, a, rv, c0;
    logic [2*DW-1:0] d, held;
    logic we, dbl, sgn;

    for (int i = 0; i < TOTAL; i++) begin
      sram[i]    = DW'(i*7 + 3);
      ref_mem[i] = DW'(i*7 + 3);
    end
    for (int b = 0; b < NB; b++) rd_r[b] = '0;
    preset(14336, 9'h1A5);
    preset(14335, 9'h012);
    preset(57342, 9'h0AB);
    preset(57343, 9'h155);

    //            we    dbl   sgn   addr   wdata      hold err  lat data
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 14336, 18'h00000, 0, 1'b0, 3, 18'h3FFA5};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 14336, 18'h00034, 1, 1'b0, 2, 18'h00000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 14335, 18'h00000, 0, 1'b0, 4, 18'h06812};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 57344, 18'h00000, 2, 1'b1, 1, 18'h00000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 57343, 18'h00000, 0, 1'b1, 1, 18'h00000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 100,   18'h3FE01, 0, 1'b0, 3, 18'h00000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 100,   18'h00000, 1, 1'b0, 4, 18'h3FE01};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 101,   18'h00000, 0, 1'b0, 3, 18'h001FF};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 101,   18'h00000, 0, 1'b0, 3, 18'h3FFFF};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 100,   18'h00000, 0, 1'b0, 3, 18'h00001};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 57342, 18'h00000, 0, 1'b0, 4, 18'h2AAAB};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 57343, 18'h00000, 0, 1'b0, 3, 18'h3FF55};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 28671, 18'h1873C, 0, 1'b0, 3, 18'h00000};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 28671, 18'h00000, 0, 1'b0, 4, 18'h1873C};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 28672, 18'h00000, 0, 1'b0, 3, 18'h000C3};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 60000, 18'h00123, 0, 1'b1, 1, 18'h00000};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 57343, 18'h00123, 0, 1'b1, 1, 18'h00000};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 28671, 18'h00000, 0, 1'b0, 3, 18'h3FF3C};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_bank_en", bank_en, 0);
    check("rst_bank_we", bank_we, 0);
    check("rst_bank_addr", bank_addr, 0);
    rst_n = 1'b1;

    // table-driven vectors
    foreach (vecs[i]) begin
      run_and_check(vecs[i].we, vecs[i].dbl, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    vecs[i].hold, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_data);
    end

    // bank port timing: single read at the first word of bank 1
    launch(1'b0, 1'b0, 1'b1, 14336, '0);
    check("t1_bank_en", bank_en, 4'b0010);
    check("t1_bank_addr", bank_addr, 0);
    check("t1_bank_we", bank_we, 0);
    drain();

    // double read straddling bank 0 -> bank 1
    launch(1'b0, 1'b1, 1'b0, 14335, '0);
    check("t2_acc0_en", bank_en, 4'b0001);
    check("t2_acc0_addr", bank_addr, 14335);
    @(negedge clk);
    check("t2_acc1_en", bank_en, 4'b0010);
    check("t2_acc1_addr", bank_addr, 0);
    @(negedge clk);
    check("t2_idle_en", bank_en, 0);
    drain();

    // out-of-range: response on the first cycle, no bank activity
    launch(1'b0, 1'b0, 1'b0, 57344, '0);
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_err", rsp_err, 1);
    check("t3_rsp_data", rsp_data, 0);
    check("t3_bank_en", bank_en, 0);
    drain();

    // double write port values
    launch(1'b1, 1'b1, 1'b0, 100, 18'h3FE01);
    check("t4_acc0_en", bank_en, 4'b0001);
    check("t4_acc0_addr", bank_addr, 100);
    check("t4_acc0_we", bank_we, 1);
    check("t4_acc0_wdata", bank_wdata, 9'h001);
    @(negedge clk);
    check("t4_acc1_addr", bank_addr, 101);
    check("t4_acc1_we", bank_we, 1);
    check("t4_acc1_wdata", bank_wdata, 9'h1FF);
    @(negedge clk);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_bank_en", bank_en, 0);
    drain();

    // backpressure with a competing request held on the request port
    launch(1'b0, 1'b0, 1'b0, 100, '0);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 12) begin
        @(negedge clk);
        n++;
      end
    end
    held = rsp_data;
    check("t5_rsp_data", held, 18'h00001);
    c0 = en_count;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_double = 1'b1;
    req_addr   = AW'(200);
    req_wdata  = {9'h0AA, 9'h055};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", rsp_valid, 1);
      check("t5_hold_data", rsp_data, held);
      check("t5_hold_req_ready", req_ready, 0);
    end
    check("t5_no_access", en_count - c0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t5_ready_after_hs", req_ready, 1);
    @(negedge clk);
    check("t5_accept_en", bank_en, 4'b0001);
    check("t5_accept_addr", bank_addr, 200);
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_double = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    ref_mem[200] = 9'h055;
    ref_mem[201] = 9'h0AA;
    drain();
    model(1'b0, 1'b1, 1'b0, 200, e, lat, d);
    run_and_check(1'b0, 1'b1, 1'b0, 200, '0, 0, e, lat, d);

    // reset during ACC1 of a double read
    launch(1'b0, 1'b1, 1'b0, 14335, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_bank_en", bank_en, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready", req_ready, 1);
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    check("t6_no_response", rv, 0);

    // randomized requests against the reference model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0:       a = int'($urandom_range(0, 65535));
        1:       a = int'($urandom_range(1, 3)) * D + int'($urandom_range(0, 3)) - 2;
        2:       a = TOTAL - 3 + int'($urandom_range(0, 4));
        default: a = int'($urandom_range(0, 63));
      endcase
      we  = 1'($urandom_range(0, 1));
      dbl = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      model(we, dbl, sgn, a, e, lat, d);
      run_and_check(we, dbl, sgn, a, 18'($urandom), int'($urandom_range(0, 3)), e, lat, d);
    end

    check("bank_port_sanity", bad_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
